// File: rtl/div_operand_sequencer.sv
// div_operand_sequencer: request FIFO and operand sequencer in front of a
// restoring divider. Buffers dividend/divisor pairs, presents one pair at a
// time to the divider, holds it for DIV_LATENCY cycles, captures the result
// and returns it over a valid/ready interface. A zero divisor is answered
// locally with quotient = all ones and remainder = dividend.
//
// Optional build macro: DIV_RESULT_CHECK_EN
//   defined   - captured divider results are checked (q*d + r == dividend,
//               r < d) and out_err reports a mismatch.
//   undefined - no checker; out_err is constant 0.

module div_operand_sequencer #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int DIV_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_dividend,
    input  logic [WIDTH-1:0]           in_divisor,
    output logic [WIDTH-1:0]           div_dividend,
    output logic [WIDTH-1:0]           div_divisor,
    input  logic [WIDTH-1:0]           div_quotient,
    input  logic [WIDTH-1:0]           div_remainder,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_quotient,
    output logic [WIDTH-1:0]           out_remainder,
    output logic                       out_div_zero,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WCNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [WCNT_W-1:0] WAIT_LOAD  = WCNT_W'(DIV_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e state_q, state_d;

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0] mem_dividend_q [DEPTH];
    logic [WIDTH-1:0] mem_dividend_d [DEPTH];
    logic [WIDTH-1:0] mem_divisor_q  [DEPTH];
    logic [WIDTH-1:0] mem_divisor_d  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Sequencer datapath registers
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0]  div_dividend_q, div_dividend_d;
    logic [WIDTH-1:0]  div_divisor_q, div_divisor_d;
    logic [WIDTH-1:0]  out_quotient_q, out_quotient_d;
    logic [WIDTH-1:0]  out_remainder_q, out_remainder_d;
    logic              out_div_zero_q, out_div_zero_d;
    logic              out_valid_q, out_valid_d;

    // FSM decoded controls
    logic push;
    logic pop;
    logic load_div;
    logic load_zero;
    logic wait_done;
    logic handshake;

    logic [WIDTH-1:0] head_dividend;
    logic [WIDTH-1:0] head_divisor;

    assign in_ready      = (count_q != FULL_COUNT);
    assign push          = in_valid && in_ready;
    assign head_dividend = mem_dividend_q[rd_ptr_q];
    assign head_divisor  = mem_divisor_q[rd_ptr_q];

    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;
    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign out_div_zero  = out_div_zero_q;
    assign out_valid     = out_valid_q;
    assign fifo_count    = count_q;
    assign busy          = (state_q != S_IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_div) begin
                    state_d = S_WAIT;
                end else if (load_zero) begin
                    state_d = S_HOLD;
                end
            end
            S_WAIT: begin
                if (wait_done) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (handshake) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output decode: pop/load/capture/handshake strobes
    always_comb begin
        pop       = 1'b0;
        load_div  = 1'b0;
        load_zero = 1'b0;
        wait_done = 1'b0;
        handshake = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head_divisor != '0) begin
                        load_div = 1'b1;
                    end else begin
                        load_zero = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                wait_done = (wait_cnt_q == '0);
            end
            S_HOLD: begin
                handshake = out_valid_q && out_ready;
            end
            default: ;
        endcase
    end

    // FIFO next-state: write on push, advance pointers, track occupancy
    always_comb begin
        mem_dividend_d = mem_dividend_q;
        mem_divisor_d  = mem_divisor_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        if (push) begin
            mem_dividend_d[wr_ptr_q] = in_dividend;
            mem_divisor_d[wr_ptr_q]  = in_divisor;
            wr_ptr_d                 = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Operand/result datapath next-state.
    // out_valid is registered from the HOLD state, so it rises one cycle
    // after HOLD entry and drops the cycle after the handshake.
    always_comb begin
        wait_cnt_d      = wait_cnt_q;
        div_dividend_d  = div_dividend_q;
        div_divisor_d   = div_divisor_q;
        out_quotient_d  = out_quotient_q;
        out_remainder_d = out_remainder_q;
        out_div_zero_d  = out_div_zero_q;
        out_valid_d     = (state_q == S_HOLD) && !handshake;

        if (load_div) begin
            div_dividend_d = head_dividend;
            div_divisor_d  = head_divisor;
            wait_cnt_d     = WAIT_LOAD;
        end else if (state_q == S_WAIT && !wait_done) begin
            wait_cnt_d = wait_cnt_q - WCNT_W'(1);
        end

        if (load_zero) begin
            out_quotient_d  = '1;
            out_remainder_d = head_dividend;
            out_div_zero_d  = 1'b1;
        end else if (wait_done) begin
            out_quotient_d  = div_quotient;
            out_remainder_d = div_remainder;
            out_div_zero_d  = 1'b0;
        end
    end

    // FIFO data storage; contents are only meaningful behind the pointers
    always_ff @(posedge clk) begin
        mem_dividend_q <= mem_dividend_d;
        mem_divisor_q  <= mem_divisor_d;
    end

    // Control and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            wait_cnt_q      <= '0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
            out_div_zero_q  <= 1'b0;
            out_valid_q     <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            wait_cnt_q      <= wait_cnt_d;
            div_dividend_q  <= div_dividend_d;
            div_divisor_q   <= div_divisor_d;
            out_quotient_q  <= out_quotient_d;
            out_remainder_q <= out_remainder_d;
            out_div_zero_q  <= out_div_zero_d;
            out_valid_q     <= out_valid_d;
        end
    end

`ifdef DIV_RESULT_CHECK_EN
    logic [2*WIDTH-1:0] chk_sum;
    logic               chk_err;
    logic               out_err_q, out_err_d;

    // Consistency check of the divider result against the held operands
    always_comb begin
        chk_sum = ({{WIDTH{1'b0}}, div_quotient} * {{WIDTH{1'b0}}, div_divisor_q})
                + {{WIDTH{1'b0}}, div_remainder};
        chk_err = (chk_sum != {{WIDTH{1'b0}}, div_dividend_q})
               || (div_remainder >= div_divisor_q);
    end

    // Error flag travels with the captured result, cleared on handshake
    always_comb begin
        out_err_d = out_err_q;
        if (load_zero || handshake) begin
            out_err_d = 1'b0;
        end else if (wait_done) begin
            out_err_d = chk_err;
        end
    end

    // Error flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_err_q <= 1'b0;
        end else begin
            out_err_q <= out_err_d;
        end
    end

    assign out_err = out_err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule
